ram8: RTL

- Eight-word register file. It is the direct consumer of the dmux8way stage: the dmux8way instance steers the write strobe `load` to exactly one of eight word registers, selected by `address`.
- A mux8way16 returns the word selected by `address` on `out`.
- It is the first sequential memory stage in the hierarchy. It is the building block for ram64 (eight ram8 instances plus an upper-address decode).

---
 rtl/hack_pkg.sv | 9 +
 rtl/dmux8way.sv | 30 +++
 rtl/mux8way16.sv | 36 +++
 rtl/register_w.sv | 27 ++
 rtl/ram8.sv | 63 ++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory hierarchy.
//   WORD_W      : data word width
//   word_t      : one data word
//   RAM8_ADDR_W : address width of an eight-word register file
package hack_pkg;
    localparam int WORD_W      = 16;
    typedef logic [WORD_W-1:0] word_t;
    localparam int RAM8_ADDR_W = 3;
endpackage

// File: rtl/dmux8way.sv
// One-to-eight demultiplexer: routes `in` to the output selected by `sel`,
// all other outputs are 0.
//   in    : bit to route
//   sel   : output select
//   a..h  : outputs for sel = 0..7
module dmux8way
    import hack_pkg::*;
(
    input  logic                   in,
    input  logic [RAM8_ADDR_W-1:0] sel,
    output logic                   a,
    output logic                   b,
    output logic                   c,
    output logic                   d,
    output logic                   e,
    output logic                   f,
    output logic                   g,
    output logic                   h
);

    assign a = in & (sel == 3'd0);
    assign b = in & (sel == 3'd1);
    assign c = in & (sel == 3'd2);
    assign d = in & (sel == 3'd3);
    assign e = in & (sel == 3'd4);
    assign f = in & (sel == 3'd5);
    assign g = in & (sel == 3'd6);
    assign h = in & (sel == 3'd7);

endmodule

// File: rtl/mux8way16.sv
// Eight-to-one word multiplexer.
//   a..h : candidate words for sel = 0..7
//   sel  : input select
//   out  : selected word
module mux8way16
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [WIDTH-1:0]       c,
    input  logic [WIDTH-1:0]       d,
    input  logic [WIDTH-1:0]       e,
    input  logic [WIDTH-1:0]       f,
    input  logic [WIDTH-1:0]       g,
    input  logic [WIDTH-1:0]       h,
    input  logic [RAM8_ADDR_W-1:0] sel,
    output logic [WIDTH-1:0]       out
);

    always_comb begin
        out = a;
        case (sel)
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/register_w.sv
// WIDTH-bit register with synchronous clear and load-enabled capture.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear (wins over load)
//   in    : data to capture
//   load  : capture enable
//   out   : stored value
module register_w
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= in;
        end
    end

endmodule

// File: rtl/ram8.sv
// Eight-word register file. Writes are synchronous (one-cycle latency),
// reads are purely combinational with no write-data bypass, so a same-cycle
// read of the written address shows the old word until the edge.
//   clk     : rising-edge clock
//   reset   : synchronous active-high clear of all words (wins over load)
//   in      : write data
//   load    : write enable for word[address]
//   address : word select for both read and write
//   out     : word[address]
module ram8
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 8          // fixed; the decode below is 8-way
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);

    logic [DEPTH-1:0] load_k;
    logic [WIDTH-1:0] words [DEPTH];

    dmux8way u_load_dec (
        .in  (load),
        .sel (address),
        .a   (load_k[0]),
        .b   (load_k[1]),
        .c   (load_k[2]),
        .d   (load_k[3]),
        .e   (load_k[4]),
        .f   (load_k[5]),
        .g   (load_k[6]),
        .h   (load_k[7])
    );

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        register_w #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .in    (in),
            .load  (load_k[k]),
            .out   (words[k])
        );
    end

    mux8way16 #(.WIDTH(WIDTH)) u_read_mux (
        .a   (words[0]),
        .b   (words[1]),
        .c   (words[2]),
        .d   (words[3]),
        .e   (words[4]),
        .f   (words[5]),
        .g   (words[6]),
        .h   (words[7]),
        .sel (address),
        .out (out)
    );

endmodule
